// File: rtl/cachepool_boot_responder.sv
// Boot/control register window: BOOT_ADDR, WAKE pulse, EOC and SCRATCH behind a reqrsp port.
// One-cycle response latency through a single response slot; a request is taken only when that slot is free or draining.
module cachepool_boot_responder #(
  parameter int unsigned NumCores      = 4,
  parameter logic [31:0] BaseAddr      = 32'h0000_0000,
  parameter logic [31:0] BootAddrReset = 32'h8000_0000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [31:0]         q_addr_i,
  input  logic                q_write_i,
  input  logic [31:0]         q_data_i,
  input  logic [3:0]          q_strb_i,
  input  logic [3:0]          q_amo_i,
  input  logic                q_valid_i,
  output logic                q_ready_o,
  output logic [31:0]         p_data_o,
  output logic                p_error_o,
  output logic                p_valid_o,
  input  logic                p_ready_i,
  output logic [31:0]         boot_addr_o,
  output logic [NumCores-1:0] wake_o,
  output logic                eoc_o,
  output logic [30:0]         eoc_code_o
);

  typedef enum logic [1:0] {
    RegBoot    = 2'd0,
    RegWake    = 2'd1,
    RegEoc     = 2'd2,
    RegScratch = 2'd3
  } reg_sel_e;

  logic [31:0]         boot_addr;
  logic [31:0]         eoc_reg;
  logic [31:0]         scratch;
  logic [NumCores-1:0] wake;
  logic                rsp_valid;
  logic [31:0]         rsp_data;
  logic                rsp_error;

  reg_sel_e            sel;
  logic                hit;
  logic                legal;
  logic                accept;
  logic                do_write;
  logic [31:0]         rdata;
  logic [NumCores-1:0] wake_nxt;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  // Window is 32 bytes; only the four doubleword-aligned offsets decode.
  always_comb begin
    sel      = reg_sel_e'(q_addr_i[4:3]);
    hit      = (q_addr_i[31:5] == BaseAddr[31:5]) && (q_addr_i[2:0] == 3'b000);
    legal    = hit && (q_amo_i == 4'd0);
    accept   = q_valid_i && q_ready_o;
    do_write = accept && legal && q_write_i;
    rdata    = 32'h0;
    case (sel)
      RegBoot:    rdata = boot_addr;
      RegWake:    rdata = 32'h0;
      RegEoc:     rdata = eoc_reg;
      RegScratch: rdata = scratch;
      default:    rdata = 32'h0;
    endcase
    wake_nxt = '0;
    if (do_write && (sel == RegWake) && q_strb_i[0]) wake_nxt = q_data_i[NumCores-1:0];
  end

  assign q_ready_o = !rsp_valid || p_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      boot_addr <= BootAddrReset;
      eoc_reg   <= 32'h0;
      scratch   <= 32'h0;
      wake      <= '0;
    end else begin
      wake <= wake_nxt;
      if (do_write) begin
        case (sel)
          RegBoot:    boot_addr <= merge(boot_addr, q_data_i, q_strb_i);
          RegEoc:     eoc_reg   <= merge(eoc_reg, q_data_i, q_strb_i);
          RegScratch: scratch   <= merge(scratch, q_data_i, q_strb_i);
          default:    ;
        endcase
      end
    end
  end

  // Read data is captured from pre-update register values in the accepting cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
      rsp_error <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= (legal && !q_write_i) ? rdata : 32'h0;
      rsp_error <= !legal;
    end else if (p_ready_i) begin
      rsp_valid <= 1'b0;
    end
  end

  assign p_valid_o   = rsp_valid;
  assign p_data_o    = rsp_data;
  assign p_error_o   = rsp_error;
  assign boot_addr_o = boot_addr;
  assign wake_o      = wake;
  assign eoc_o       = eoc_reg[0];
  assign eoc_code_o  = eoc_reg[31:1];

endmodule

// File: tb/tb_cachepool_boot_responder.sv
// Bench for cachepool_boot_responder: directed scenarios plus random traffic against a register-map model.
module tb_cachepool_boot_responder;
  localparam int NC = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   q_addr = '0;
  logic          q_write = 1'b0;
  logic [31:0]   q_data = '0;
  logic [3:0]    q_strb = '0;
  logic [3:0]    q_amo = '0;
  logic          q_valid = 1'b0;
  logic          q_ready;
  logic [31:0]   p_data;
  logic          p_error;
  logic          p_valid;
  logic          p_ready = 1'b1;
  logic [31:0]   boot_addr;
  logic [NC-1:0] wake;
  logic          eoc;
  logic [30:0]   eoc_code;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state of the register window
  logic [31:0] m_boot, m_eoc, m_scratch;

  cachepool_boot_responder #(.NumCores(NC), .BaseAddr(BASE), .BootAddrReset(32'h8000_0000)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .q_addr_i(q_addr), .q_write_i(q_write), .q_data_i(q_data), .q_strb_i(q_strb),
    .q_amo_i(q_amo), .q_valid_i(q_valid), .q_ready_o(q_ready),
    .p_data_o(p_data), .p_error_o(p_error), .p_valid_o(p_valid), .p_ready_i(p_ready),
    .boot_addr_o(boot_addr), .wake_o(wake), .eoc_o(eoc), .eoc_code_o(eoc_code)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_boot = 32'h8000_0000;
    m_eoc = 32'h0;
    m_scratch = 32'h0;
  endtask

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                              input logic [3:0] s, input logic [3:0] m,
                              output logic [31:0] ed, output logic ee, output logic [NC-1:0] ew);
    logic [31:0] off;
    logic ok;
    off = a - BASE;
    ok = (off < 32) && (off % 8 == 0) && (m == 4'd0);
    ed = 32'h0;
    ee = !ok;
    ew = '0;
    if (ok) begin
      case (off)
        0: if (w) m_boot = apply_strb(m_boot, d, s); else ed = m_boot;
        8: if (w && s[0]) ew = d[NC-1:0];
        16: if (w) m_eoc = apply_strb(m_eoc, d, s); else ed = m_eoc;
        default: if (w) m_scratch = apply_strb(m_scratch, d, s); else ed = m_scratch;
      endcase
    end
  endtask

  // Entered just after a rising edge with the response slot empty.
  task automatic xact(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic [3:0] m,
                      output logic pv, output logic [31:0] pd, output logic pe,
                      output logic [NC-1:0] wk, output logic pv2, output logic [NC-1:0] wk2);
    q_addr = a; q_write = w; q_data = d; q_strb = s; q_amo = m;
    q_valid = 1'b1; p_ready = 1'b1;
    @(posedge clk); #1;
    pv = p_valid; pd = p_data; pe = p_error; wk = wake;
    q_valid = 1'b0;
    q_addr = $urandom; q_write = 1'b1; q_data = $urandom; q_strb = 4'hF; q_amo = '0;
    @(posedge clk); #1;
    pv2 = p_valid; wk2 = wake;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (p_valid !== 1'b0) begin n_bad++; $display("FAIL reset_p_valid: got %b want 0", p_valid); end
    n_cmp++; if (p_data !== 32'h0 || p_error !== 1'b0) begin n_bad++; $display("FAIL reset_rsp: got %h/%b want 0/0", p_data, p_error); end
    n_cmp++; if (boot_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL reset_boot: got %h want 80000000", boot_addr); end
    n_cmp++; if ({eoc, eoc_code} !== 32'h0 || wake !== '0) begin n_bad++; $display("FAIL reset_eoc_wake: got %b/%h/%b want 0", eoc, eoc_code, wake); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (q_ready !== 1'b1) begin n_bad++; $display("FAIL reset_q_ready: got %b want 1", q_ready); end
  endtask

  task automatic test_boot_addr();
    logic pv, pe, pv2; logic [31:0] pd, ed; logic ee; logic [NC-1:0] wk, wk2, ew;
    model_access(32'h0, 1'b0, 32'h0, 4'h0, 4'h0, ed, ee, ew);
    xact(32'h0, 1'b0, 32'h0, 4'h0, 4'h0, pv, pd, pe, wk, pv2, wk2);
    n_cmp++; if (pv !== 1'b1 || pd !== 32'h8000_0000 || pe !== 1'b0) begin n_bad++; $display("FAIL boot_read: got %b/%h/%b want 1/80000000/0", pv, pd, pe); end
    n_cmp++; if (pv2 !== 1'b0) begin n_bad++; $display("FAIL boot_read_drain: p_valid got %b want 0", pv2); end
    model_access(32'h0, 1'b1, 32'h8000_3000, 4'hF, 4'h0, ed, ee, ew);
    xact(32'h0, 1'b1, 32'h8000_3000, 4'hF, 4'h0, pv, pd, pe, wk, pv2, wk2);
    n_cmp++; if (boot_addr !== 32'h8000_3000 || pd !== 32'h0 || pe !== 1'b0) begin n_bad++; $display("FAIL boot_write_full: got %h (rsp %h/%b) want 80003000", boot_addr, pd, pe); end
    model_access(32'h0, 1'b1, 32'hFFFF_FFFF, 4'h1, 4'h0, ed, ee, ew);
    xact(32'h0, 1'b1, 32'hFFFF_FFFF, 4'h1, 4'h0, pv, pd, pe, wk, pv2, wk2);
    n_cmp++; if (boot_addr !== 32'h8000_30FF) begin n_bad++; $display("FAIL boot_write_byte0: got %h want 800030FF", boot_addr); end
  endtask

  task automatic test_wake();
    logic pv, pe, pv2; logic [31:0] pd, ed; logic ee; logic [NC-1:0] wk, wk2, ew;
    model_access(32'h8, 1'b1, 32'h5, 4'hF, 4'h0, ed, ee, ew);
    xact(32'h8, 1'b1, 32'h5, 4'hF, 4'h0, pv, pd, pe, wk, pv2, wk2);
    n_cmp++; if (wk !== 4'b0101) begin n_bad++; $display("FAIL wake_pulse: got %b want 0101", wk); end
    n_cmp++; if (wk2 !== 4'b0000) begin n_bad++; $display("FAIL wake_single_cycle: got %b want 0000", wk2); end
    xact(32'h8, 1'b0, 32'h0, 4'h0, 4'h0, pv, pd, pe, wk, pv2, wk2);
    n_cmp++; if (pv !== 1'b1 || pd !== 32'h0 || pe !== 1'b0 || wk !== '0) begin n_bad++; $display("FAIL wake_read: got %b/%h/%b/%b want 1/0/0/0", pv, pd, pe, wk); end
    xact(32'h8, 1'b1, 32'hF, 4'hE, 4'h0, pv, pd, pe, wk, pv2, wk2);
    n_cmp++; if (wk !== '0) begin n_bad++; $display("FAIL wake_no_strb0: got %b want 0000", wk); end
  endtask

  task automatic test_eoc_errors();
    logic pv, pe, pv2; logic [31:0] pd, ed; logic ee; logic [NC-1:0] wk, wk2, ew;
    model_access(32'h10, 1'b1, 32'h7, 4'hF, 4'h0, ed, ee, ew);
    xact(32'h10, 1'b1, 32'h7, 4'hF, 4'h0, pv, pd, pe, wk, pv2, wk2);
    n_cmp++; if (eoc !== 1'b1 || eoc_code !== 31'd3) begin n_bad++; $display("FAIL eoc_write: got %b/%0d want 1/3", eoc, eoc_code); end
    xact(32'h4, 1'b0, 32'h0, 4'h0, 4'h0, pv, pd, pe, wk, pv2, wk2);
    n_cmp++; if (pv !== 1'b1 || pe !== 1'b1 || pd !== 32'h0) begin n_bad++; $display("FAIL miss_read: got %b/%h/%b want 1/0/1", pv, pd, pe); end
    xact(32'h18, 1'b1, 32'h1234_5678, 4'hF, 4'h2, pv, pd, pe, wk, pv2, wk2);
    n_cmp++; if (pe !== 1'b1 || pd !== 32'h0) begin n_bad++; $display("FAIL amo_error: got %h/%b want 0/1", pd, pe); end
    xact(32'h8, 1'b1, 32'hF, 4'hF, 4'h1, pv, pd, pe, wk, pv2, wk2);
    n_cmp++; if (pe !== 1'b1 || wk !== '0) begin n_bad++; $display("FAIL amo_wake: got err %b wake %b want 1/0000", pe, wk); end
    model_access(32'h18, 1'b0, 32'h0, 4'h0, 4'h0, ed, ee, ew);
    xact(32'h18, 1'b0, 32'h0, 4'h0, 4'h0, pv, pd, pe, wk, pv2, wk2);
    n_cmp++; if (pd !== ed || pe !== 1'b0) begin n_bad++; $display("FAIL amo_no_side_effect: scratch got %h want %h", pd, ed); end
    n_cmp++; if (boot_addr !== m_boot || eoc !== m_eoc[0] || eoc_code !== m_eoc[31:1]) begin n_bad++; $display("FAIL err_regs_unchanged: got %h/%b/%h", boot_addr, eoc, eoc_code); end
  endtask

  task automatic test_random();
    logic pv, pe, pv2; logic [31:0] pd, ed, a, d; logic ee, w; logic [NC-1:0] wk, wk2, ew;
    logic [3:0] s, m;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3: a = BASE + 32'($urandom_range(0, 3) * 8);
        4:          a = BASE + 32'($urandom_range(0, 3) * 8 + $urandom_range(1, 7));
        5:          a = BASE + 32'h20 + 32'($urandom_range(0, 3) * 8);
        default:    a = $urandom;
      endcase
      w = 1'($urandom);
      d = $urandom;
      s = 4'($urandom);
      m = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      model_access(a, w, d, s, m, ed, ee, ew);
      xact(a, w, d, s, m, pv, pd, pe, wk, pv2, wk2);
      n_cmp++; if (pv !== 1'b1 || pd !== ed || pe !== ee) begin n_bad++; $display("FAIL rnd_rsp[%0d] a=%h w=%b: got %b/%h/%b want 1/%h/%b", n, a, w, pv, pd, pe, ed, ee); end
      n_cmp++; if (wk !== ew || wk2 !== '0 || pv2 !== 1'b0) begin n_bad++; $display("FAIL rnd_wake[%0d]: got %b then %b (pv %b) want %b then 0", n, wk, wk2, pv2, ew); end
      n_cmp++; if (boot_addr !== m_boot || {eoc_code, eoc} !== m_eoc) begin n_bad++; $display("FAIL rnd_regs[%0d]: got %h/%h want %h/%h", n, boot_addr, {eoc_code, eoc}, m_boot, m_eoc); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea, eb, ec; logic ee; logic [NC-1:0] ew;
    model_access(32'h0, 1'b0, 32'h0, 4'h0, 4'h0, ea, ee, ew);
    model_access(32'h10, 1'b0, 32'h0, 4'h0, 4'h0, eb, ee, ew);
    model_access(32'h18, 1'b0, 32'h0, 4'h0, 4'h0, ec, ee, ew);
    p_ready = 1'b0;
    q_write = 1'b0; q_amo = '0; q_strb = '0; q_addr = 32'h0; q_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (p_valid !== 1'b1 || p_data !== ea) begin n_bad++; $display("FAIL b2b_first: got %b/%h want 1/%h", p_valid, p_data, ea); end
    q_addr = 32'h10;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (q_ready !== 1'b0 || p_valid !== 1'b1 || p_data !== ea || p_error !== 1'b0) begin n_bad++; $display("FAIL b2b_stall[%0d]: ready %b valid %b data %h want 0/1/%h", k, q_ready, p_valid, p_data, ea); end
      @(posedge clk); #1;
    end
    p_ready = 1'b1;
    #1;
    n_cmp++; if (q_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_release: got %b want 1", q_ready); end
    @(posedge clk); #1;
    n_cmp++; if (p_valid !== 1'b1 || p_data !== eb) begin n_bad++; $display("FAIL b2b_second: got %b/%h want 1/%h", p_valid, p_data, eb); end
    q_addr = 32'h18;
    @(posedge clk); #1;
    n_cmp++; if (p_valid !== 1'b1 || p_data !== ec) begin n_bad++; $display("FAIL b2b_third: got %b/%h want 1/%h", p_valid, p_data, ec); end
    q_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (p_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", p_valid); end
  endtask

  task automatic test_reset_mid();
    logic pv, pe, pv2; logic [31:0] pd, ed; logic ee; logic [NC-1:0] wk, wk2, ew;
    p_ready = 1'b0;
    q_addr = 32'h18; q_write = 1'b1; q_data = 32'hDEAD_BEEF; q_strb = 4'hF; q_amo = '0; q_valid = 1'b1;
    @(posedge clk); #1;
    q_valid = 1'b0;
    n_cmp++; if (p_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pending: got %b want 1", p_valid); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (p_valid !== 1'b0 || p_data !== 32'h0 || p_error !== 1'b0) begin n_bad++; $display("FAIL rstmid_async: got %b/%h/%b want 0/0/0", p_valid, p_data, p_error); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    p_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      n_cmp++; if (p_valid !== 1'b0 || q_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_no_rsp: valid %b ready %b want 0/1", p_valid, q_ready); end
    end
    model_access(32'h18, 1'b0, 32'h0, 4'h0, 4'h0, ed, ee, ew);
    xact(32'h18, 1'b0, 32'h0, 4'h0, 4'h0, pv, pd, pe, wk, pv2, wk2);
    n_cmp++; if (pv !== 1'b1 || pd !== ed || pe !== 1'b0) begin n_bad++; $display("FAIL rstmid_scratch: got %b/%h/%b want 1/%h/0", pv, pd, pe, ed); end
  endtask

  initial begin
    test_reset();
    test_boot_addr();
    test_wake();
    test_eoc_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cachepool_boot_responder.md
CACHEPOOL_BOOT_RESPONDER -- requirements
Module: cachepool_boot_responder

Interface
REQ-001: Parameter NumCores, default 4: number of wake-up lines driven.
REQ-002: Parameter BaseAddr, default 32'h0000_0000: 32-byte-aligned base of the register window.
REQ-003: Parameter BootAddrReset, default 32'h8000_0000: reset value of BOOT_ADDR.
REQ-004: Port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-005: Port rst_ni, input, 1: asynchronous, active-low reset.
REQ-006: Port q_addr_i, input, 32: request byte address.
REQ-007: Port q_write_i, input, 1: 1 = write, 0 = read.
REQ-008: Port q_data_i, input, 32: write data.
REQ-009: Port q_strb_i, input, 4: byte strobes for writes.
REQ-010: Port q_amo_i, input, 4: reqrsp AMO opcode; 0 = AMONone.
REQ-011: Port q_valid_i / q_ready_o, input / output, 1 each: request handshake.
REQ-012: Port p_data_o, output, 32: response read data.
REQ-013: Port p_error_o, output, 1: response error flag.
REQ-014: Port p_valid_o / p_ready_i, output / input, 1 each: response handshake.
REQ-015: Port boot_addr_o, output, 32: current BOOT_ADDR contents.
REQ-016: Port wake_o, output, NumCores: per-core one-cycle wake-up pulse.
REQ-017: Port eoc_o, output, 1: end-of-computation flag; eoc_code_o, output, 31: exit code.

Function
REQ-018: Register map at offset q_addr_i - BaseAddr: 0x00 BOOT_ADDR (RW), 0x08 WAKE (WO, reads 0), 0x10 EOC (RW: bit0 = eoc, bits31:1 = code), 0x18 SCRATCH (RW, reset 0).
REQ-019: Hit = q_addr_i[31:5] equals BaseAddr[31:5] and q_addr_i[4:0] is one of 0x00/0x08/0x10/0x18; any other address is a miss.
REQ-020: q_ready_o = !p_valid_o || p_ready_i (single-entry response slot, combinational ready).
REQ-021: Request accepted in cycle where q_valid_i && q_ready_o; response presented with p_valid_o = 1 in the following cycle (latency 1).
REQ-022: Throughput one request per cycle when p_ready_i held high.
REQ-023: p_valid_o, p_data_o, p_error_o held stable while p_valid_o && !p_ready_i; no new request accepted then.
REQ-024: Response slot cleared when p_valid_o && p_ready_i and no new request accepted that cycle.
REQ-025: Read hit: p_data_o = register value before any same-cycle update, p_error_o = 0.
REQ-026: Write hit: byte i of the target register updated iff q_strb_i[i]; update visible on boot_addr_o/eoc_o/eoc_code_o the cycle after acceptance; p_data_o = 0, p_error_o = 0.
REQ-027: Write hit to WAKE: wake_o[i] = q_data_i[i] && q_strb_i[0] for exactly the cycle after acceptance, 0 otherwise; bits above NumCores ignored.
REQ-028: Miss or q_amo_i != 0: no state change, no wake pulse, p_error_o = 1, p_data_o = 0.
REQ-029: q_valid_i without acceptance has no side effects.

Reset
REQ-030: On rst_ni low, asynchronously: boot_addr_o = BootAddrReset, SCRATCH = 0, eoc_o = 0, eoc_code_o = 0, wake_o = 0, p_valid_o = 0, p_data_o = 0, p_error_o = 0.
REQ-031: Reset asserted mid-transaction discards the pending response; after release q_ready_o = 1 and no response is emitted for pre-reset requests.

Verification
REQ-032: After reset, read 0x00 with p_ready_i = 1 -> p_valid_o one cycle later, p_data_o = 32'h8000_0000, p_error_o = 0.
REQ-033: Write 0x00 data 32'h8000_3000 strb 4'b1111 -> boot_addr_o = 32'h8000_3000 next cycle; then write 32'hFFFF_FFFF strb 4'b0001 -> boot_addr_o = 32'h8000_30FF.
REQ-034: Write WAKE data 32'h5 (NumCores = 4) -> wake_o = 4'b0101 for exactly one cycle, then 4'b0000; read WAKE -> 0.
REQ-035: Write EOC data 32'h0000_0007 -> eoc_o = 1, eoc_code_o = 3; read 0x04 or AMO request -> p_error_o = 1, registers unchanged.
REQ-036: Three back-to-back reads with p_ready_i = 0 for 3 cycles -> q_ready_o = 0 after first accept, first response held stable; p_ready_i = 1 -> remaining responses on consecutive cycles in order.
REQ-037: Write SCRATCH 32'hDEAD_BEEF, assert rst_ni low while its response is stalled -> p_valid_o = 0 immediately, SCRATCH reads 0 after release.
